id_ctrl_pipe: RTL
=================

Name: id_ctrl_pipe

Overview:
- Next-generation control unit for the 16-bit, 16-opcode ISA: ADD SUB XOR RED SLL SRA ROR PADDSB LW SW LLB LHB B BR PCS HLT.
- Decodes the IF/ID instruction and registers the control bundle into the ID/EX stage.
- Detects load-use hazards against its own registered EX stage and squashes on branch flush.
- Runs the HLT drain/halt state machine. Sits between the IF/ID register and the execute stage.

Parameters:
- REG_AW, 4, register-address width; register 0 is hardwired zero.
- HALT_DRAIN, 3, cycles from HLT leaving ID until halted asserts (EX, MEM, WB drain); legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  16  IF/ID word: opcode [15:12], rd [11:8], rs [7:4], rt [3:0], cond [11:9], imm [8:0].
- instr_valid  in  1  IF/ID holds a real instruction.
- flush  in  1  an older branch resolved taken; squash ID.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch, ex_branch_reg, ex_pcs  out  1 each  registered controls.
- ex_aluop  out  4  ALU function.
- ex_rd, ex_rs, ex_rt  out  REG_AW each  registered register fields.
- ex_cond  out  3  branch condition.
- ex_imm  out  9  raw instr[8:0]; EX sign- or zero-extends.
- halted  out  1  core halted; sticky until rst.

Behaviour:
- Reset: every ex_* output is 0, halted=0, state RUN, drain counter 0. stall is 0 while rst=1.
- Latency: a decoded instruction appears on ex_* exactly one cycle after it is accepted in ID.
- Decode table (RW regwrite, MR memread, MW memwrite, M2R memtoreg, AS alusrc):
  - ADD/SUB/XOR/RED/PADDSB: RW, AS=0, aluop=opcode.
  - SLL/SRA/ROR: RW, AS=1, aluop=opcode.
  - LW: RW MR M2R AS, aluop=0.
  - SW: MW AS, aluop=0.
  - LLB/LHB: RW AS, aluop=opcode.
  - B: branch.
  - BR: branch, branch_reg.
  - PCS: RW, pcs.
  - HLT: all controls 0.
- ex_regwrite is forced to 0 when rd==0.
- Source usage:
  - rs+rt: opcodes 0-3, 7.
  - rs only: shifts, LW, BR.
  - rs and rd (store data): SW.
  - rd only: LLB, LHB.
  - none: B, PCS, HLT.
- Load-use stall: stall=1 when all of the following hold. The ID/EX register then loads a bubble (ex_valid=0, all controls 0) and IF/ID holds.
  - state RUN, instr_valid, !flush.
  - ex_valid, ex_memread, ex_rd!=0.
  - ex_rd equals any used source register.
- Flush: ID/EX loads a bubble and stall=0. flush takes priority over the load-use stall and over HLT decode.
- Invalid instruction (instr_valid=0): bubble.
- FSM, RUN:
  - Valid HLT in ID with !flush and no stall -> DRAIN. Counter loads HALT_DRAIN and the HLT enters EX as a bubble.
- FSM, DRAIN:
  - stall=1 and bubbles are issued every cycle; counter decrements.
  - flush=1 -> RUN and counter cleared (HLT was wrong-path).
  - Counter reaching 0 -> HALTED.
- FSM, HALTED:
  - halted=1, stall=1, bubbles only. flush is ignored.
  - Only rst leaves this state.
- rst asserted in any state: next state RUN. Reset has priority over every other event.
- Back-to-back load-use: the stall lasts exactly one cycle. The bubble clears ex_memread, so the next cycle proceeds.

Decomposition:
- Shared package isa_pkg holds:
  - opcode_t enum with the 16 opcodes.
  - ctrl_t packed struct: regwrite, memread, memwrite, memtoreg, alusrc, branch, branch_reg, pcs, aluop.
  - src_use_t struct: use_rs, use_rt, use_rd.
  - halt_state_t enum: RUN, DRAIN, HALTED.
  - CTRL_NOP constant.
- One combinational sub-module, instr_decode: maps instr to ctrl_t plus src_use_t.
- id_ctrl_pipe holds the hazard logic, the ID/EX register, the FSM and the drain counter.

Test Plan:
- LW r3,r1,2 (0x8312) accepted, then ADD r4,r3,r5 (0x0435) -> stall=1 for one cycle, ex_valid=0 that cycle, ADD on ex_* the next cycle with ex_rd=4.
- LW r0,... followed by ADD r4,r0,r5 -> no stall.
- LW r3 then SW r3,r2,0 (0x9320) -> stall (rd-field use).
- LW r3 then B cond=1 -> no stall.
- ADD r0,r1,r2 -> ex_valid=1, ex_regwrite=0.
- flush=1 in the same cycle as a load-use hazard -> stall=0, bubble issued.
- HLT (0xF000) valid with HALT_DRAIN=3 -> stall=1 from the next cycle, halted=1 exactly 4 cycles after acceptance and held.
- HLT accepted, flush asserted 1 cycle later -> returns to RUN, halted stays 0, stall drops.
- HALTED, then rst high for 1 cycle -> halted=0, all ex_*=0, stall=0. Repeat with rst asserted mid-DRAIN.
- Every opcode 0x0-0xF with rd=1 -> ex_* matches the decode table one cycle later; ex_imm=instr[8:0].

Source files
------------

// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
// Shared types for the 16-bit, 16-opcode ISA control path.
//   opcode_t     : the 16 opcodes in encoding order
//   ctrl_t       : control bundle carried into the ID/EX stage
//   src_use_t    : which instruction fields are read as source registers
//   halt_state_t : HLT drain/halt state machine states
//   CTRL_NOP     : all-zero control bundle used for bubbles
// ---------------------------------------------------------------------------
package isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       branch_reg;
        logic       pcs;
        logic [3:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic use_rs;
        logic use_rt;
        logic use_rd;
    } src_use_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Purely combinational opcode decoder.
//   opcode  in  4   instr[15:12] of the IF/ID word
//   ctrl    out     control bundle for the instruction
//   src_use out     which of rs / rt / rd are read as sources
// The rd==0 regwrite suppression lives in the pipeline stage, since it
// depends on the register field rather than the opcode.
// ---------------------------------------------------------------------------
module instr_decode
    import isa_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output src_use_t   src_use
);

    opcode_t op;
    assign op = opcode_t'(opcode);

    always_comb begin
        ctrl    = CTRL_NOP;
        src_use = '0;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.aluop     = opcode;
                src_use.use_rs = 1'b1;
                src_use.use_rt = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                ctrl.regwrite  = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.aluop     = opcode;
                src_use.use_rs = 1'b1;
            end
            OP_LW: begin
                ctrl.regwrite  = 1'b1;
                ctrl.memread   = 1'b1;
                ctrl.memtoreg  = 1'b1;
                ctrl.alusrc    = 1'b1;
                src_use.use_rs = 1'b1;
            end
            // rd carries the store data register
            OP_SW: begin
                ctrl.memwrite  = 1'b1;
                ctrl.alusrc    = 1'b1;
                src_use.use_rs = 1'b1;
                src_use.use_rd = 1'b1;
            end
            // byte loads merge into the existing rd value
            OP_LLB, OP_LHB: begin
                ctrl.regwrite  = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.aluop     = opcode;
                src_use.use_rd = 1'b1;
            end
            OP_B: begin
                ctrl.branch = 1'b1;
            end
            OP_BR: begin
                ctrl.branch     = 1'b1;
                ctrl.branch_reg = 1'b1;
                src_use.use_rs  = 1'b1;
            end
            OP_PCS: begin
                ctrl.regwrite = 1'b1;
                ctrl.pcs      = 1'b1;
            end
            default: begin
                ctrl    = CTRL_NOP;
                src_use = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// id_ctrl_pipe
// Decode stage control: decodes the IF/ID word, registers the control
// bundle into ID/EX, detects load-use hazards, squashes on flush and runs
// the HLT drain/halt state machine.
//   clk, rst        clock and synchronous active-high reset
//   instr           IF/ID instruction word
//   instr_valid     IF/ID holds a real instruction
//   flush           older branch taken; squash ID
//   stall           hold PC and IF/ID (combinational)
//   ex_*            registered ID/EX controls and register fields
//   halted          core halted, sticky until rst
// ---------------------------------------------------------------------------
module id_ctrl_pipe
    import isa_pkg::*;
#(
    parameter int REG_AW     = 4,
    parameter int HALT_DRAIN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic              ex_branch,
    output logic              ex_branch_reg,
    output logic              ex_pcs,
    output logic [3:0]        ex_aluop,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [2:0]        ex_cond,
    output logic [8:0]        ex_imm,
    output logic              halted
);

    ctrl_t             dec_ctrl;
    src_use_t          dec_use;
    logic [REG_AW-1:0] id_rd, id_rs, id_rt;
    logic              is_hlt, src_match, load_use, accept;

    halt_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ex_valid_q, ex_valid_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic [2:0]        ex_cond_q, ex_cond_d;
    logic [8:0]        ex_imm_q, ex_imm_d;

    instr_decode u_decode (
        .opcode  (instr[15:12]),
        .ctrl    (dec_ctrl),
        .src_use (dec_use)
    );

    assign id_rd  = instr[8 +: REG_AW];
    assign id_rs  = instr[4 +: REG_AW];
    assign id_rt  = instr[0 +: REG_AW];
    assign is_hlt = (opcode_t'(instr[15:12]) == OP_HLT);

    // A load in EX whose destination is read by the instruction in ID must
    // wait one cycle; loads to r0 never create a dependency.
    always_comb begin
        src_match = (dec_use.use_rs && (id_rs == ex_rd_q)) ||
                    (dec_use.use_rt && (id_rt == ex_rd_q)) ||
                    (dec_use.use_rd && (id_rd == ex_rd_q));
        load_use  = (state_q == RUN) && instr_valid && !flush &&
                    ex_valid_q && ex_ctrl_q.memread && (ex_rd_q != '0) &&
                    src_match;
        accept    = (state_q == RUN) && instr_valid && !flush && !load_use;
    end

    // A flush during drain redirects the PC, so it must not be held.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN:     stall = load_use;
                DRAIN:   stall = !flush;
                HALTED:  stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    // Next-state logic. Everything defaults to a bubble; only an accepted
    // non-HLT instruction in RUN loads real contents into ID/EX.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_valid_d = 1'b0;
        ex_ctrl_d  = CTRL_NOP;
        ex_rd_d    = '0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        ex_cond_d  = '0;
        ex_imm_d   = '0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    if (is_hlt) begin
                        state_d = DRAIN;
                        cnt_d   = 4'(HALT_DRAIN);
                    end else begin
                        ex_valid_d         = 1'b1;
                        ex_ctrl_d          = dec_ctrl;
                        ex_ctrl_d.regwrite = dec_ctrl.regwrite && (id_rd != '0);
                        ex_rd_d            = id_rd;
                        ex_rs_d            = id_rs;
                        ex_rt_d            = id_rt;
                        ex_cond_d          = instr[11:9];
                        ex_imm_d           = instr[8:0];
                    end
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State, drain counter and ID/EX register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CTRL_NOP;
            ex_rd_q    <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_cond_q  <= '0;
            ex_imm_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_cond_q  <= ex_cond_d;
            ex_imm_q   <= ex_imm_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_regwrite   = ex_ctrl_q.regwrite;
    assign ex_memread    = ex_ctrl_q.memread;
    assign ex_memwrite   = ex_ctrl_q.memwrite;
    assign ex_memtoreg   = ex_ctrl_q.memtoreg;
    assign ex_alusrc     = ex_ctrl_q.alusrc;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_branch_reg = ex_ctrl_q.branch_reg;
    assign ex_pcs        = ex_ctrl_q.pcs;
    assign ex_aluop      = ex_ctrl_q.aluop;
    assign ex_rd         = ex_rd_q;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ex_cond       = ex_cond_q;
    assign ex_imm        = ex_imm_q;
    assign halted        = (state_q == HALTED);

endmodule
